// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: ALU (A) and load (B) results each park in a one-entry holding
// register and compete for the single registered register-file write port.
module regfile_wb_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [3:0]       a_dest,
   input  logic [31:0]      a_value,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [3:0]       b_dest,
   input  logic [31:0]      b_value,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   output logic             hazard,
   output logic             writeBackEn,
   output logic [3:0]       destWB,
   output logic [31:0]      valueWB,
   output logic [CNT_W-1:0] wb_count
);

   logic             a_full_q, a_full_d, b_full_q, b_full_d;
   logic [3:0]       a_dest_q, a_dest_d, b_dest_q, b_dest_d;
   logic [31:0]      a_value_q, a_value_d, b_value_q, b_value_d;
   logic             a_older_q, a_older_d, b_older_q, b_older_d;
   logic             last_b_q, last_b_d;
   logic             wb_en_q, wb_en_d;
   logic [3:0]       wb_dest_q, wb_dest_d;
   logic [31:0]      wb_value_q, wb_value_d;
   logic [CNT_W-1:0] wb_count_q, wb_count_d;
   logic             grant_a_s, grant_b_s, a_load_s, b_load_s, same_dest_s;

   function automatic logic reads_idx(input logic [3:0] idx, input logic [3:0] s1,
                                      input logic [3:0] s2);
      return (s1 == idx) || (s2 == idx);
   endfunction

   assign same_dest_s = (a_dest_q == b_dest_q);

   // Arbitration: same-destination pairs drain oldest first so the later write wins.
   always_comb begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      if (a_full_q && b_full_q) begin
         if (same_dest_s && a_older_q) begin
            grant_a_s = 1'b1;
         end else if (same_dest_s && b_older_q) begin
            grant_b_s = 1'b1;
         end else if (last_b_q) begin
            grant_a_s = 1'b1;
         end else begin
            grant_b_s = 1'b1;
         end
      end else if (a_full_q) begin
         grant_a_s = 1'b1;
      end else if (b_full_q) begin
         grant_b_s = 1'b1;
      end else begin
         grant_a_s = 1'b0;
         grant_b_s = 1'b0;
      end
   end

   assign a_ready  = !a_full_q || grant_a_s;
   assign b_ready  = !b_full_q || grant_b_s;
   assign a_load_s = a_valid && a_ready;
   assign b_load_s = b_valid && b_ready;

   // Decode hazard against both pending entries and the write in flight.
   always_comb begin
      hazard = 1'b0;
      if ((a_full_q && reads_idx(a_dest_q, src1, src2)) ||
          (b_full_q && reads_idx(b_dest_q, src1, src2)) ||
          (wb_en_q  && reads_idx(wb_dest_q, src1, src2))) begin
         hazard = 1'b1;
      end else begin
         hazard = 1'b0;
      end
   end

   // Next state for holding registers, age, pointer and write port.
   always_comb begin
      a_full_d   = a_load_s || (a_full_q && !grant_a_s);
      b_full_d   = b_load_s || (b_full_q && !grant_b_s);
      a_dest_d   = a_load_s ? a_dest  : a_dest_q;
      a_value_d  = a_load_s ? a_value : a_value_q;
      b_dest_d   = b_load_s ? b_dest  : b_dest_q;
      b_value_d  = b_load_s ? b_value : b_value_q;
      a_older_d  = 1'b0;
      b_older_d  = 1'b0;
      last_b_d   = last_b_q;
      wb_en_d    = grant_a_s || grant_b_s;
      wb_dest_d  = wb_dest_q;
      wb_value_d = wb_value_q;
      wb_count_d = wb_count_q;

      // A lone load behind a surviving entry makes the survivor the older one.
      if (a_load_s && b_load_s) begin
         a_older_d = 1'b0;
         b_older_d = 1'b0;
      end else if (a_load_s) begin
         b_older_d = b_full_d;
      end else if (b_load_s) begin
         a_older_d = a_full_d;
      end else begin
         a_older_d = a_older_q && a_full_d && b_full_d;
         b_older_d = b_older_q && a_full_d && b_full_d;
      end

      if (a_full_q && b_full_q) begin
         last_b_d = grant_b_s;
      end else begin
         last_b_d = last_b_q;
      end

      if (grant_a_s) begin
         wb_dest_d  = a_dest_q;
         wb_value_d = a_value_q;
      end else if (grant_b_s) begin
         wb_dest_d  = b_dest_q;
         wb_value_d = b_value_q;
      end else begin
         wb_dest_d  = wb_dest_q;
         wb_value_d = wb_value_q;
      end

      if (wb_en_d && (wb_count_q != {CNT_W{1'b1}})) begin
         wb_count_d = wb_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         wb_count_d = wb_count_q;
      end
   end

   // State registers; reset drops held writes and points the tie-breaker at B.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_full_q   <= 1'b0;
         b_full_q   <= 1'b0;
         a_dest_q   <= 4'd0;
         b_dest_q   <= 4'd0;
         a_value_q  <= 32'd0;
         b_value_q  <= 32'd0;
         a_older_q  <= 1'b0;
         b_older_q  <= 1'b0;
         last_b_q   <= 1'b1;
         wb_en_q    <= 1'b0;
         wb_dest_q  <= 4'd0;
         wb_value_q <= 32'd0;
         wb_count_q <= {CNT_W{1'b0}};
      end else begin
         a_full_q   <= a_full_d;
         b_full_q   <= b_full_d;
         a_dest_q   <= a_dest_d;
         b_dest_q   <= b_dest_d;
         a_value_q  <= a_value_d;
         b_value_q  <= b_value_d;
         a_older_q  <= a_older_d;
         b_older_q  <= b_older_d;
         last_b_q   <= last_b_d;
         wb_en_q    <= wb_en_d;
         wb_dest_q  <= wb_dest_d;
         wb_value_q <= wb_value_d;
         wb_count_q <= wb_count_d;
      end
   end

   assign writeBackEn = wb_en_q;
   assign destWB      = wb_dest_q;
   assign valueWB     = wb_value_q;
   assign wb_count    = wb_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a
// timestamp-based reference model of the two holding registers.
module tb_regfile_wb_arbiter;

   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          a_valid, b_valid, a_ready, b_ready, hazard, writeBackEn;
   logic [3:0]    a_dest, b_dest, src1, src2, destWB;
   logic [31:0]   a_value, b_value, valueWB;
   logic [CW-1:0] wb_count;

   int tests_run = 0;
   int failed    = 0;

   regfile_wb_arbiter #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_value(a_value),
      .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_value(b_value),
      .src1(src1), .src2(src2), .hazard(hazard),
      .writeBackEn(writeBackEn), .destWB(destWB), .valueWB(valueWB), .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   // Reference model: each entry remembers the cycle it was loaded in.
   bit          m_af, m_bf, m_last_a, m_wen;
   logic [3:0]  m_ad, m_bd, m_dwb;
   logic [31:0] m_av, m_bv, m_vwb;
   int          m_ats, m_bts, m_cnt, m_now;

   function automatic void m_reset();
      m_af = 1'b0; m_bf = 1'b0; m_last_a = 1'b0; m_wen = 1'b0;
      m_ad = 4'd0; m_bd = 4'd0; m_dwb = 4'd0;
      m_av = 32'd0; m_bv = 32'd0; m_vwb = 32'd0;
      m_ats = 0; m_bts = 0; m_cnt = 0; m_now = 0;
   endfunction

   function automatic bit m_pick_a();
      if (!m_af) return 1'b0;
      if (!m_bf) return 1'b1;
      if ((m_ad == m_bd) && (m_ats != m_bts)) return (m_ats < m_bts);
      return !m_last_a;
   endfunction

   function automatic bit m_ready_a();
      return !m_af || m_pick_a();
   endfunction

   function automatic bit m_ready_b();
      return !m_bf || !m_pick_a();
   endfunction

   function automatic bit m_hazard(input logic [3:0] s1, input logic [3:0] s2);
      bit h;
      h = 1'b0;
      if (m_af && ((s1 == m_ad) || (s2 == m_ad))) h = 1'b1;
      if (m_bf && ((s1 == m_bd) || (s2 == m_bd))) h = 1'b1;
      if (m_wen && ((s1 == m_dwb) || (s2 == m_dwb))) h = 1'b1;
      return h;
   endfunction

   task automatic tick();
      bit ga, gb, ra, rb;
      ga = m_af && m_pick_a();
      gb = m_bf && !m_pick_a();
      ra = !m_af || ga;
      rb = !m_bf || gb;
      @(posedge clk);
      if (ga || gb) begin
         if (m_af && m_bf) m_last_a = ga;
         m_wen = 1'b1;
         m_dwb = ga ? m_ad : m_bd;
         m_vwb = ga ? m_av : m_bv;
         if (m_cnt < CMAX) m_cnt++;
      end else begin
         m_wen = 1'b0;
      end
      if (ga) m_af = 1'b0;
      if (gb) m_bf = 1'b0;
      if (a_valid && ra) begin m_af = 1'b1; m_ad = a_dest; m_av = a_value; m_ats = m_now; end
      if (b_valid && rb) begin m_bf = 1'b1; m_bd = b_dest; m_bv = b_value; m_bts = m_now; end
      m_now++;
      #1;
   endtask

   task automatic reset_dut();
      a_valid = 1'b0; b_valid = 1'b0; a_dest = 4'd0; b_dest = 4'd0;
      a_value = 32'd0; b_value = 32'd0; src1 = 4'd0; src2 = 4'd0;
      rst = 1'b0;
      m_reset();
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
   endtask

   task automatic test_reset();
      a_valid = 1'b1; a_dest = 4'd6; a_value = 32'h1234_5678; b_valid = 1'b1; b_dest = 4'd6;
      src1 = 4'd0; src2 = 4'd6;
      @(posedge clk); #1;
      tests_run++; if (writeBackEn !== 1'b0) begin failed++; $display("FAIL reset_wen: got %b expected 0", writeBackEn); end
      tests_run++; if (destWB !== 4'd0) begin failed++; $display("FAIL reset_dest: got %h expected 0", destWB); end
      tests_run++; if (valueWB !== 32'd0) begin failed++; $display("FAIL reset_value: got %h expected 0", valueWB); end
      tests_run++; if (wb_count !== 4'd0) begin failed++; $display("FAIL reset_count: got %0d expected 0", wb_count); end
      tests_run++; if ({a_ready, b_ready} !== 2'b11) begin failed++; $display("FAIL reset_ready: got %b expected 11", {a_ready, b_ready}); end
      tests_run++; if (hazard !== 1'b0) begin failed++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
   endtask

   task automatic test_single();
      reset_dut();
      a_valid = 1'b1; a_dest = 4'd3; a_value = 32'hDEAD_BEEF; #1;
      tests_run++; if (a_ready !== 1'b1) begin failed++; $display("FAIL single_ready: got %b expected 1", a_ready); end
      tick();
      a_valid = 1'b0;
      tests_run++; if (writeBackEn !== 1'b0) begin failed++; $display("FAIL single_early: got %b expected 0", writeBackEn); end
      tick();
      tests_run++; if ({writeBackEn, destWB, valueWB} !== {1'b1, 4'd3, 32'hDEAD_BEEF}) begin failed++; $display("FAIL single_write: got %b/%h/%h expected 1/3/deadbeef", writeBackEn, destWB, valueWB); end
      tests_run++; if (wb_count !== 4'd1) begin failed++; $display("FAIL single_count: got %0d expected 1", wb_count); end
      tick();
      tests_run++; if ({writeBackEn, destWB, valueWB} !== {1'b0, 4'd3, 32'hDEAD_BEEF}) begin failed++; $display("FAIL single_hold: got %b/%h/%h expected 0/3/deadbeef", writeBackEn, destWB, valueWB); end
   endtask

   task automatic test_contention();
      reset_dut();
      a_valid = 1'b1; a_dest = 4'd1; a_value = 32'h11; b_valid = 1'b1; b_dest = 4'd2; b_value = 32'h22;
      tick();
      a_valid = 1'b0; b_valid = 1'b0; #1;
      tests_run++; if ({a_ready, b_ready} !== 2'b10) begin failed++; $display("FAIL tie1_ready: got %b expected 10", {a_ready, b_ready}); end
      tick();
      tests_run++; if ({writeBackEn, destWB, valueWB} !== {1'b1, 4'd1, 32'h11}) begin failed++; $display("FAIL tie1_first: got %b/%h/%h expected 1/1/11", writeBackEn, destWB, valueWB); end
      tick();
      tests_run++; if ({writeBackEn, destWB, valueWB} !== {1'b1, 4'd2, 32'h22}) begin failed++; $display("FAIL tie1_second: got %b/%h/%h expected 1/2/22", writeBackEn, destWB, valueWB); end
      a_valid = 1'b1; a_dest = 4'd4; a_value = 32'h44; b_valid = 1'b1; b_dest = 4'd5; b_value = 32'h55;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
      tests_run++; if ({writeBackEn, destWB, valueWB} !== {1'b1, 4'd5, 32'h55}) begin failed++; $display("FAIL tie2_first: got %b/%h/%h expected 1/5/55", writeBackEn, destWB, valueWB); end
      tick();
      tests_run++; if ({writeBackEn, destWB, valueWB} !== {1'b1, 4'd4, 32'h44}) begin failed++; $display("FAIL tie2_second: got %b/%h/%h expected 1/4/44", writeBackEn, destWB, valueWB); end
      tests_run++; if (wb_count !== 4'd4) begin failed++; $display("FAIL tie_count: got %0d expected 4", wb_count); end
   endtask

   task automatic test_ordering();
      reset_dut();
      a_valid = 1'b1; a_dest = 4'd6; a_value = 32'h66; b_valid = 1'b1; b_dest = 4'd7; b_value = 32'hB;
      tick();
      a_dest = 4'd7; a_value = 32'hA; b_valid = 1'b0; #1;
      tests_run++; if (a_ready !== 1'b1) begin failed++; $display("FAIL order_reload_ready: got %b expected 1", a_ready); end
      tick();
      a_valid = 1'b0;
      tests_run++; if ({writeBackEn, destWB, valueWB} !== {1'b1, 4'd6, 32'h66}) begin failed++; $display("FAIL order_prior: got %b/%h/%h expected 1/6/66", writeBackEn, destWB, valueWB); end
      tick();
      tests_run++; if ({writeBackEn, destWB, valueWB} !== {1'b1, 4'd7, 32'hB}) begin failed++; $display("FAIL order_older: got %b/%h/%h expected 1/7/b", writeBackEn, destWB, valueWB); end
      tick();
      tests_run++; if ({writeBackEn, destWB, valueWB} !== {1'b1, 4'd7, 32'hA}) begin failed++; $display("FAIL order_newer: got %b/%h/%h expected 1/7/a", writeBackEn, destWB, valueWB); end
   endtask

   task automatic test_hazard();
      reset_dut();
      src1 = 4'd9; src2 = 4'd0; #1;
      tests_run++; if (hazard !== 1'b0) begin failed++; $display("FAIL hazard_idle: got %b expected 0", hazard); end
      b_valid = 1'b1; b_dest = 4'd9; b_value = 32'h99;
      tick();
      b_valid = 1'b0; #1;
      tests_run++; if (hazard !== 1'b1) begin failed++; $display("FAIL hazard_hold: got %b expected 1", hazard); end
      src1 = 4'd3; src2 = 4'd3; #1;
      tests_run++; if (hazard !== 1'b0) begin failed++; $display("FAIL hazard_nomatch: got %b expected 0", hazard); end
      src1 = 4'd9;
      tick();
      tests_run++; if ({writeBackEn, hazard} !== 2'b11) begin failed++; $display("FAIL hazard_wb: got %b expected 11", {writeBackEn, hazard}); end
      src1 = 4'd0; src2 = 4'd9; #1;
      tests_run++; if (hazard !== 1'b1) begin failed++; $display("FAIL hazard_src2: got %b expected 1", hazard); end
      tick();
      tests_run++; if (hazard !== 1'b0) begin failed++; $display("FAIL hazard_clear: got %b expected 0", hazard); end
   endtask

   task automatic test_reset_midop();
      reset_dut();
      a_valid = 1'b1; a_dest = 4'd1; a_value = 32'h1; b_valid = 1'b1; b_dest = 4'd2; b_value = 32'h2;
      tick();
      a_dest = 4'd3; a_value = 32'h3; b_valid = 1'b0;
      tick();
      a_valid = 1'b0;
      tests_run++; if ({writeBackEn, wb_count} !== {1'b1, 4'd1}) begin failed++; $display("FAIL midop_pre: got %b/%0d expected 1/1", writeBackEn, wb_count); end
      #2 rst = 1'b0;
      m_reset();
      #1;
      tests_run++; if ({writeBackEn, wb_count, destWB, valueWB} !== {1'b0, 4'd0, 4'd0, 32'd0}) begin failed++; $display("FAIL midop_async: got %b/%0d/%h/%h expected 0/0/0/0", writeBackEn, wb_count, destWB, valueWB); end
      tests_run++; if ({a_ready, b_ready} !== 2'b11) begin failed++; $display("FAIL midop_ready: got %b expected 11", {a_ready, b_ready}); end
      @(posedge clk);
      #3 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++; if ({writeBackEn, wb_count} !== {1'b0, 4'd0}) begin failed++; $display("FAIL midop_discard: got %b/%0d expected 0/0", writeBackEn, wb_count); end
      end
      a_valid = 1'b1; a_dest = 4'd5; a_value = 32'h55;
      tick();
      a_valid = 1'b0;
      tick();
      tests_run++; if ({writeBackEn, destWB, valueWB, wb_count} !== {1'b1, 4'd5, 32'h55, 4'd1}) begin failed++; $display("FAIL midop_new: got %b/%h/%h/%0d expected 1/5/55/1", writeBackEn, destWB, valueWB, wb_count); end
   endtask

   task automatic test_back_to_back();
      reset_dut();
      for (int i = 0; i < 20; i++) begin
         a_valid = 1'b1; a_dest = 4'(i); a_value = 32'(i + 100); #1;
         tests_run++; if (a_ready !== 1'b1) begin failed++; $display("FAIL b2b_ready: got %b expected 1 at %0d", a_ready, i); end
         tick();
         if (i > 0) begin
            tests_run++; if ({writeBackEn, destWB, valueWB} !== {1'b1, 4'(i - 1), 32'(i + 99)}) begin failed++; $display("FAIL b2b_write: got %b/%h/%h at %0d", writeBackEn, destWB, valueWB, i); end
            tests_run++; if (wb_count !== 4'((i < CMAX) ? i : CMAX)) begin failed++; $display("FAIL b2b_count: got %0d expected %0d", wb_count, (i < CMAX) ? i : CMAX); end
         end
      end
      a_valid = 1'b0;
      tick();
      tick();
      tests_run++; if ({writeBackEn, wb_count} !== {1'b0, 4'd15}) begin failed++; $display("FAIL sat_final: got %b/%0d expected 0/15", writeBackEn, wb_count); end
   endtask

   task automatic test_random();
      bit hold_a, hold_b;
      hold_a = 1'b0; hold_b = 1'b0;
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         if (!hold_a) begin
            a_valid = ($urandom_range(0, 3) != 0); a_dest = 4'($urandom_range(0, 3)); a_value = $urandom;
         end
         if (!hold_b) begin
            b_valid = ($urandom_range(0, 3) != 0); b_dest = 4'($urandom_range(0, 3)); b_value = $urandom;
         end
         src1 = 4'($urandom_range(0, 5)); src2 = 4'($urandom_range(0, 5));
         #1;
         tests_run++; if ({a_ready, b_ready} !== {m_ready_a(), m_ready_b()}) begin failed++; $display("FAIL rand_ready: got %b expected %b%b at %0d", {a_ready, b_ready}, m_ready_a(), m_ready_b(), i); end
         tests_run++; if (hazard !== m_hazard(src1, src2)) begin failed++; $display("FAIL rand_hazard: got %b expected %b at %0d", hazard, m_hazard(src1, src2), i); end
         hold_a = a_valid && !m_ready_a();
         hold_b = b_valid && !m_ready_b();
         tick();
         tests_run++; if ({writeBackEn, destWB, valueWB} !== {m_wen, m_dwb, m_vwb}) begin failed++; $display("FAIL rand_write: got %b/%h/%h expected %b/%h/%h at %0d", writeBackEn, destWB, valueWB, m_wen, m_dwb, m_vwb, i); end
         tests_run++; if (wb_count !== 4'(m_cnt)) begin failed++; $display("FAIL rand_count: got %0d expected %0d at %0d", wb_count, m_cnt, i); end
      end
   endtask

   initial begin
      a_valid = 1'b0; b_valid = 1'b0; a_dest = 4'd0; b_dest = 4'd0;
      a_value = 32'd0; b_value = 32'd0; src1 = 4'd0; src2 = 4'd0;
      m_reset();
      test_reset();
      test_single();
      test_contention();
      test_ordering();
      test_hazard();
      test_reset_midop();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of the committed-write counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately, independent of clk.
REQ-004 a_valid  input  1  requester A (ALU result path) offers a write.
REQ-005 a_ready  output  1  A write accepted this cycle when a_valid&&a_ready.
REQ-006 a_dest  input  4  A destination register index.
REQ-007 a_value  input  32  A write data.
REQ-008 b_valid / b_ready / b_dest / b_value  input/output/input/input  1/1/4/32  requester B (memory load path), same meaning as A.
REQ-009 src1, src2  input  4  register indices being read by decode.
REQ-010 hazard  output  1  a read index matches a pending write.
REQ-011 writeBackEn  output  1  register-file write strobe, registered.
REQ-012 destWB  output  4  register-file write index, registered.
REQ-013 valueWB  output  32  register-file write data, registered.
REQ-014 wb_count  output  CNT_W  number of writes issued, saturating.

Function
REQ-015 Each requester SHALL own a one-entry holding register (full flag, dest, value).
REQ-016 X_ready SHALL equal !hold_X_full || grant_X (combinational), where X is A or B.
REQ-017 On X_valid&&X_ready the holding register SHALL load X_dest/X_value and set full at the edge.
REQ-018 Each cycle at most one full holding register SHALL be granted; grant_X clears hold_X_full at the edge unless it is reloaded at the same edge.
REQ-019 Only one full: grant it.
REQ-020 Both full with different dest: round-robin; grant the requester not granted last; the last-grant pointer resets to B, so A wins the first tie.
REQ-021 Both full with equal dest: grant the older entry (age flag set when an entry loads while the other is full); this overrides round-robin, and the pointer still updates to the granted requester.
REQ-022 Grant SHALL register to outputs at the same edge: writeBackEn<=1, destWB<=granted dest, valueWB<=granted value.
REQ-023 With no grant, writeBackEn<=0, and destWB/valueWB SHALL hold their last values.
REQ-024 Latency: an accepted write with no contention appears on writeBackEn exactly 1 cycle after acceptance, and 2 cycles when it loses arbitration once.
REQ-025 Throughput: a sole active requester SHALL sustain one write per cycle.
REQ-026 hazard SHALL be combinational: 1 iff src1 or src2 equals the dest of any full holding register, or equals destWB while writeBackEn=1.
REQ-027 wb_count SHALL increment by 1 at each edge that sets writeBackEn, and SHALL saturate at all-ones.
REQ-028 A requester SHALL keep dest and value stable while valid&&!ready; the block does not check this.

Reset
REQ-029 rst=0 SHALL asynchronously clear both full flags and the age flag, set the pointer to B, and drive writeBackEn=0, destWB=0, valueWB=0, wb_count=0.
REQ-030 Reset mid-operation SHALL discard held writes without issuing them; a_ready=b_ready=1 SHALL hold during reset.
REQ-031 The first edge after rst rises SHALL behave as a normal cycle, with no dead cycle.

Verification
REQ-032 Single write: A offers dest=3, value=0xDEADBEEF at cycle 0 -> a_ready=1, and cycle 1 shows writeBackEn=1, destWB=3, valueWB=0xDEADBEEF, wb_count=1.
REQ-033 Contention: A (dest 1, 0x11) and B (dest 2, 0x22) accepted in the same cycle -> A writes at +1 and B at +2; next tie (dest 4/5) -> B first.
REQ-034 Ordering: B loads dest=7, 0xB at cycle 0 and loses to a prior A; A loads dest=7, 0xA at cycle 1 -> destWB=7 shows 0xB, then 0xA.
REQ-035 Hazard: hold_B full with dest=9, src1=9 -> hazard=1; the cycle after its write issues, hazard=1 via destWB; the following cycle, hazard=0.
REQ-036 Reset mid-op: both holds full, assert rst=0 mid-cycle -> writeBackEn=0 and wb_count=0 at once, and after release no write issues until a new valid arrives.
REQ-037 Saturation: with CNT_W=4, issue 20 writes -> wb_count stops at 15.
